wb_dma_arbiter: RTL and testbench

//  Shares the processor board's Wishbone bus between the 1801VM2 core and NDMA DMA masters (disk/network controllers).

---
 rtl/wb_dma_arbiter.sv | 198 +++++++++++++++++++
 tb/tb_wb_dma_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/wb_dma_arbiter.sv
// wb_dma_arbiter: shares the Wishbone bus between the 1801VM2 core and NDMA
// DMA masters. Ownership only changes between transactions, every owner change
// passes through one dead cycle, and DMA masters are served round-robin with a
// bounded tenure. All outputs come straight from flops.

// Grant exclusivity checker: core grant and DMA grants are never active together.
module wb_dma_arbiter_chk #(
    parameter int NDMA = 2
) (
    input logic            clk_p,
    input logic            dclo,
    input logic            cpu_gnt,
    input logic [NDMA-1:0] dma_gnt
);

    grant_onehot_a: assert property (@(posedge clk_p) disable iff (dclo)
        $onehot0({cpu_gnt, dma_gnt}));

endmodule

module wb_dma_arbiter #(
    parameter int NDMA     = 2,
    parameter int MAXHOLD  = 64,
    parameter int CPU_SLOT = 4
) (
    input  logic            clk_p,
    input  logic            dclo,
    input  logic            cpu_cyc_i,
    input  logic [NDMA-1:0] dma_req,
    input  logic [NDMA-1:0] dma_cyc,
    output logic            cpu_gnt,
    output logic [NDMA-1:0] dma_gnt,
    output logic [2:0]      bus_sel,
    output logic            bus_idle
);

    localparam logic [1:0] CPU_OWN  = 2'd0;
    localparam logic [1:0] HANDOVER = 2'd1;
    localparam logic [1:0] GRANT    = 2'd2;
    localparam logic [1:0] RELEASE  = 2'd3;

    localparam logic [15:0] MAX_HOLD_C   = 16'(MAXHOLD);
    localparam logic [15:0] SLOT_C       = 16'(CPU_SLOT);
    localparam logic [2:0]  LAST_C       = 3'(NDMA - 1);
    localparam logic        HOLD_LIMIT_C = (MAXHOLD != 32'sd0);

    // First requester at or after ptr, wrapping at NDMA-1; ptr if none.
    function automatic logic [2:0] rr_pick(input logic [7:0] req, input logic [2:0] ptr);
        logic [2:0] sel;
        logic       found;
        int         j;
        sel   = ptr;
        found = 1'b0;
        for (int i = 0; i < NDMA; i++) begin
            j = (int'(ptr) + i) % NDMA;
            if (!found && req[3'(j)]) begin
                sel   = 3'(j);
                found = 1'b1;
            end else begin
                found = found;
            end
        end
        return sel;
    endfunction

    logic [1:0]      state_r, state_nxt_s;
    logic [15:0]     slot_r, slot_nxt_s, slot_inc_s;
    logic [15:0]     hold_r, hold_nxt_s, hold_inc_s;
    logic [2:0]      rr_r, rr_nxt_s;
    logic [2:0]      win_r, win_nxt_s;
    logic [7:0]      req8_s, cyc8_s;
    logic            req_k_s, cyc_k_s, limit_s;
    logic            cpu_gnt_nxt_s, bus_idle_nxt_s;
    logic [NDMA-1:0] dma_gnt_nxt_s;
    logic [2:0]      bus_sel_nxt_s;
    logic            cpu_gnt_r, bus_idle_r;
    logic [NDMA-1:0] dma_gnt_r;
    logic [2:0]      bus_sel_r;

    // Next-state, counter and round-robin pointer logic.
    always_comb begin
        state_nxt_s = state_r;
        slot_nxt_s  = slot_r;
        hold_nxt_s  = hold_r;
        rr_nxt_s    = rr_r;
        win_nxt_s   = win_r;
        slot_inc_s  = (slot_r >= SLOT_C) ? slot_r : slot_r + 16'd1;
        hold_inc_s  = (hold_r == 16'hFFFF) ? hold_r : hold_r + 16'd1;
        req8_s      = 8'(dma_req);
        cyc8_s      = 8'(dma_cyc);
        req_k_s     = req8_s[win_r];
        cyc_k_s     = cyc8_s[win_r];
        // The counters are compared at their post-edge value, so a tenure
        // of MAXHOLD means exactly MAXHOLD granted cycles.
        limit_s     = HOLD_LIMIT_C && (hold_inc_s >= MAX_HOLD_C);
        case (state_r)
            CPU_OWN: begin
                slot_nxt_s = slot_inc_s;
                if ((|dma_req) && !cpu_cyc_i && (slot_inc_s >= SLOT_C)) begin
                    state_nxt_s = HANDOVER;
                    win_nxt_s   = rr_pick(req8_s, rr_r);
                end else begin
                    state_nxt_s = CPU_OWN;
                end
            end
            HANDOVER: begin
                if (req_k_s) begin
                    state_nxt_s = GRANT;
                    hold_nxt_s  = 16'd0;
                end else begin
                    state_nxt_s = CPU_OWN;
                    slot_nxt_s  = 16'd0;
                end
            end
            GRANT: begin
                hold_nxt_s = hold_inc_s;
                // Never cut a master off inside its own bus cycle.
                if (!cyc_k_s && (!req_k_s || limit_s)) begin
                    state_nxt_s = RELEASE;
                    rr_nxt_s    = (win_r >= LAST_C) ? 3'd0 : win_r + 3'd1;
                end else begin
                    state_nxt_s = GRANT;
                end
            end
            RELEASE: begin
                state_nxt_s = CPU_OWN;
                slot_nxt_s  = 16'd0;
            end
            default: begin
                state_nxt_s = CPU_OWN;
                slot_nxt_s  = 16'd0;
            end
        endcase
    end

    // Output values decoded from the next state so they can be registered.
    always_comb begin
        cpu_gnt_nxt_s  = 1'b0;
        dma_gnt_nxt_s  = '0;
        bus_sel_nxt_s  = 3'd0;
        bus_idle_nxt_s = 1'b0;
        case (state_nxt_s)
            CPU_OWN: begin
                cpu_gnt_nxt_s = 1'b1;
            end
            HANDOVER, RELEASE: begin
                bus_idle_nxt_s = 1'b1;
            end
            GRANT: begin
                for (int i = 0; i < NDMA; i++) begin
                    dma_gnt_nxt_s[i] = (win_nxt_s == 3'(i));
                end
                bus_sel_nxt_s = win_nxt_s + 3'd1;
            end
            default: begin
                bus_idle_nxt_s = 1'b1;
            end
        endcase
    end

    // State, counters, pointer and registered outputs; reset drops grants at once.
    always_ff @(posedge clk_p or posedge dclo) begin
        if (dclo) begin
            state_r    <= CPU_OWN;
            slot_r     <= 16'd0;
            hold_r     <= 16'd0;
            rr_r       <= 3'd0;
            win_r      <= 3'd0;
            cpu_gnt_r  <= 1'b1;
            dma_gnt_r  <= '0;
            bus_sel_r  <= 3'd0;
            bus_idle_r <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            slot_r     <= slot_nxt_s;
            hold_r     <= hold_nxt_s;
            rr_r       <= rr_nxt_s;
            win_r      <= win_nxt_s;
            cpu_gnt_r  <= cpu_gnt_nxt_s;
            dma_gnt_r  <= dma_gnt_nxt_s;
            bus_sel_r  <= bus_sel_nxt_s;
            bus_idle_r <= bus_idle_nxt_s;
        end
    end

    assign cpu_gnt  = cpu_gnt_r;
    assign dma_gnt  = dma_gnt_r;
    assign bus_sel  = bus_sel_r;
    assign bus_idle = bus_idle_r;

    wb_dma_arbiter_chk #(.NDMA(NDMA)) u_chk (
        .clk_p   (clk_p),
        .dclo    (dclo),
        .cpu_gnt (cpu_gnt_r),
        .dma_gnt (dma_gnt_r)
    );

endmodule

// File: tb/tb_wb_dma_arbiter.sv
// Testbench for wb_dma_arbiter: a cycle-level ownership model predicts the
// outputs after every clock edge and queues them; a monitor on the falling
// edge pops and compares. Directed scenarios are followed by random traffic.
module tb_wb_dma_arbiter;

    localparam int NDMA     = 2;
    localparam int MAXHOLD  = 8;
    localparam int CPU_SLOT = 4;

    typedef struct packed {
        logic            cpu;
        logic [NDMA-1:0] dma;
        logic [2:0]      sel;
        logic            idle;
    } out_t;

    logic            clk_p = 1'b0;
    logic            dclo;
    logic            cpu_cyc_i;
    logic [NDMA-1:0] dma_req;
    logic [NDMA-1:0] dma_cyc;
    logic            cpu_gnt;
    logic [NDMA-1:0] dma_gnt;
    logic [2:0]      bus_sel;
    logic            bus_idle;

    int errors = 0;
    int checks = 0;
    out_t exp_q[$];

    // Ownership model: owner -1 = core, k = DMA master; dead marks a gap cycle.
    int owner   = -1;
    int pending = -1;
    bit dead    = 1'b0;
    int cpu_run = 0;
    int tenure  = 0;
    int rr      = 0;

    wb_dma_arbiter #(.NDMA(NDMA), .MAXHOLD(MAXHOLD), .CPU_SLOT(CPU_SLOT)) dut (
        .clk_p     (clk_p),
        .dclo      (dclo),
        .cpu_cyc_i (cpu_cyc_i),
        .dma_req   (dma_req),
        .dma_cyc   (dma_cyc),
        .cpu_gnt   (cpu_gnt),
        .dma_gnt   (dma_gnt),
        .bus_sel   (bus_sel),
        .bus_idle  (bus_idle)
    );

    always #5 clk_p = ~clk_p;

    function automatic bit bit_of(input logic [NDMA-1:0] v, input int j);
        return ((32'(v) >> j) & 32'd1) != 32'd0;
    endfunction

    // Reference model: advance ownership on each rising edge, queue expected outputs.
    always @(posedge clk_p) begin
        out_t e;
        if (dclo) begin
            owner = -1; pending = -1; dead = 1'b0;
            cpu_run = 0; tenure = 0; rr = 0;
        end else if (dead) begin
            if (pending >= 0 && bit_of(dma_req, pending)) begin
                owner  = pending;
                tenure = 0;
            end else begin
                owner   = -1;
                cpu_run = 0;
            end
            pending = -1;
            dead    = 1'b0;
        end else if (owner < 0) begin
            if (cpu_run < 1000) cpu_run = cpu_run + 1;
            if (dma_req != '0 && !cpu_cyc_i && cpu_run >= CPU_SLOT) begin
                for (int i = 0; i < NDMA; i++) begin
                    if (pending < 0 && bit_of(dma_req, (rr + i) % NDMA))
                        pending = (rr + i) % NDMA;
                end
                dead = 1'b1;
            end
        end else begin
            tenure = tenure + 1;
            if (!bit_of(dma_cyc, owner) && (!bit_of(dma_req, owner) || tenure >= MAXHOLD)) begin
                rr      = (owner + 1) % NDMA;
                owner   = -1;
                pending = -1;
                dead    = 1'b1;
            end
        end
        e.cpu  = !dead && owner < 0;
        e.dma  = (!dead && owner >= 0) ? NDMA'(1 << owner) : '0;
        e.sel  = (!dead && owner >= 0) ? 3'(owner + 1) : 3'd0;
        e.idle = dead;
        exp_q.push_back(e);
    end

    // Monitor: compare the DUT outputs against the queued prediction each cycle.
    always @(negedge clk_p) begin
        out_t e;
        out_t a;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            a = {cpu_gnt, dma_gnt, bus_sel, bus_idle};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL outputs t=%0t got cpu=%b dma=%b sel=%0d idle=%b want cpu=%b dma=%b sel=%0d idle=%b",
                         $time, a.cpu, a.dma, a.sel, a.idle, e.cpu, e.dma, e.sel, e.idle);
            end
            checks++;
            if (!$onehot0({cpu_gnt, dma_gnt})) begin
                errors++;
                $display("FAIL onehot t=%0t got cpu=%b dma=%b want at most one grant", $time, cpu_gnt, dma_gnt);
            end
        end
    end

    task automatic check(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s t=%0t got %b want %b", name, $time, got, want);
        end
    endtask

    task automatic wait_gnt_k(input int k, input int limit);
        bit seen = 1'b0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk_p);
            seen = bit_of(dma_gnt, k);
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL grant_timeout master %0d got no grant want grant within %0d cycles", k, limit);
        end
    endtask

    task automatic wait_any_gnt(input int limit, output logic [NDMA-1:0] seen);
        seen = '0;
        for (int i = 0; i < limit && seen == '0; i++) begin
            @(negedge clk_p);
            seen = dma_gnt;
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NDMA-1:0] seen;
        dclo = 1'b1; cpu_cyc_i = 1'b0; dma_req = '0; dma_cyc = '0;
        repeat (2) @(negedge clk_p);
        check("reset_cpu_gnt", cpu_gnt, 1'b1);
        check("reset_dma_gnt_zero", dma_gnt == '0, 1'b1);
        check("reset_bus_sel_zero", bus_sel == 3'd0, 1'b1);
        check("reset_bus_idle", bus_idle, 1'b0);
        dclo = 1'b0;

        // Core busy blocks the handover; it follows one edge after cyc falls.
        cpu_cyc_i = 1'b1; dma_req = 2'b01;
        repeat (5) @(negedge clk_p);
        check("busy_core_keeps_gnt", cpu_gnt, 1'b1);
        cpu_cyc_i = 1'b0;
        @(negedge clk_p);
        check("handover_cpu_gnt_low", cpu_gnt, 1'b0);
        check("handover_idle", bus_idle, 1'b1);
        @(negedge clk_p);
        check("grant_dma0", dma_gnt == 2'b01, 1'b1);
        check("grant_sel1", bus_sel == 3'd1, 1'b1);

        // Master 0 stays in its cycle past the hold limit.
        dma_cyc = 2'b01;
        repeat (12) @(negedge clk_p);
        check("held_past_limit", dma_gnt[0], 1'b1);
        dma_cyc = 2'b00;
        @(negedge clk_p);
        check("release_after_cyc", dma_gnt[0], 1'b0);
        check("release_idle", bus_idle, 1'b1);
        dma_req = 2'b00;
        @(negedge clk_p);
        check("cpu_back_after_release", cpu_gnt, 1'b1);

        // Both masters request continuously: alternating bounded tenures.
        dma_req = 2'b11;
        repeat (60) @(negedge clk_p);
        dma_req = 2'b00;
        repeat (20) @(negedge clk_p);

        // Request withdrawn during the dead slot: no grant pulse.
        dma_req = 2'b10;
        @(negedge clk_p);
        dma_req = 2'b00;
        check("withdraw_handover_idle", bus_idle, 1'b1);
        @(negedge clk_p);
        check("withdraw_cpu_back", cpu_gnt, 1'b1);
        check("withdraw_no_dma", dma_gnt == '0, 1'b1);

        // Asynchronous reset during master 1's tenure, then RR restarts at 0.
        repeat (6) @(negedge clk_p);
        dma_req = 2'b11;
        wait_gnt_k(1, 200);
        #1 dclo = 1'b1;
        #1;
        check("async_reset_cpu_gnt", cpu_gnt, 1'b1);
        check("async_reset_dma_zero", dma_gnt == '0, 1'b1);
        check("async_reset_sel_zero", bus_sel == 3'd0, 1'b1);
        @(negedge clk_p);
        @(negedge clk_p);
        dclo = 1'b0;
        wait_any_gnt(100, seen);
        check("first_grant_after_reset_dma0", seen == 2'b01, 1'b1);
        dma_req = 2'b00;
        repeat (6) @(negedge clk_p);

        // Random request and cycle traffic.
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk_p);
            for (int k = 0; k < NDMA; k++) begin
                if ($urandom_range(0, 7) == 0) dma_req[k] = ~dma_req[k];
                dma_cyc[k] = ($urandom_range(0, 1) == 1);
            end
            cpu_cyc_i = ($urandom_range(0, 3) == 0);
        end
        dma_req = '0; dma_cyc = '0; cpu_cyc_i = 1'b0;
        repeat (6) @(negedge clk_p);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
